// File: rtl/difftest_step_scheduler.sv
// Shares one host step channel among difftest cores: batches per-core commit
// counts, issues them round-robin and folds host result codes into sim status.
module difftest_step_scheduler #(
    parameter int NUM_CORES  = 2,
    parameter int STEP_WIDTH = 8,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_CORES*STEP_WIDTH-1:0] core_step,
    output logic [NUM_CORES-1:0]            core_ready,
    output logic                            issue_valid,
    output logic [2:0]                      issue_core,
    output logic [STEP_WIDTH-1:0]           issue_nstep,
    input  logic                            issue_ready,
    input  logic                            result_valid,
    input  logic [7:0]                      result_code,
    output logic                            sim_done,
    output logic                            sim_fail,
    output logic                            perf_clean,
    output logic                            perf_dump,
    output logic                            protocol_err,
    output logic                            pending
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_e;

    localparam logic [ACC_WIDTH-1:0] ACC_ONES  = '1;
    localparam logic [ACC_WIDTH-1:0] STEP_MAX  = ACC_WIDTH'({STEP_WIDTH{1'b1}});
    localparam logic [ACC_WIDTH-1:0] READY_MAX = ACC_ONES - STEP_MAX;

    state_e                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q [NUM_CORES];
    logic [ACC_WIDTH-1:0]  acc_d [NUM_CORES];
    logic [2:0]            core_q, core_d;
    logic [2:0]            last_q, last_d;
    logic [STEP_WIDTH-1:0] nstep_q, nstep_d;
    logic                  done_q, done_d;
    logic                  fail_q, fail_d;
    logic                  clean_q, clean_d;
    logic                  dump_q, dump_d;
    logic                  perr_q, perr_d;

    logic                  gnt_found;
    logic [2:0]            gnt_idx;
    logic [ACC_WIDTH-1:0]  gnt_acc;
    logic [STEP_WIDTH-1:0] gnt_n;
    logic                  grant;
    logic                  drop_any;
    logic                  acc_nz;
    logic                  code_cont, code_warm, code_done, code_fail;

    // Rotating priority: first nonzero accumulator after the last grant.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_acc   = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!gnt_found && i == (int'(last_q) + k) % NUM_CORES &&
                    acc_q[i] != '0) begin
                    gnt_found = 1'b1;
                    gnt_idx   = 3'(i);
                    gnt_acc   = acc_q[i];
                end
            end
        end
    end

    assign gnt_n = (gnt_acc > STEP_MAX) ? '1 : gnt_acc[STEP_WIDTH-1:0];
    assign grant = (state_q == S_IDLE) && gnt_found;

    always_comb begin
        core_ready = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_ready[i] = acc_q[i] <= READY_MAX;
        end
    end

    // Headroom check via core_ready guarantees the add never wraps.
    always_comb begin
        drop_any = 1'b0;
        acc_nz   = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            acc_d[i] = acc_q[i];
            if (core_ready[i]) begin
                acc_d[i] = acc_q[i] +
                    ACC_WIDTH'(core_step[i*STEP_WIDTH +: STEP_WIDTH]);
            end else if (core_step[i*STEP_WIDTH +: STEP_WIDTH] != '0) begin
                drop_any = 1'b1;
            end
            if (grant && gnt_idx == 3'(i)) begin
                acc_d[i] = acc_d[i] - ACC_WIDTH'(gnt_n);
            end
            if (acc_q[i] != '0) begin
                acc_nz = 1'b1;
            end
        end
    end

    assign code_cont = result_code == 8'd0;
    assign code_warm = result_code == 8'd4;
    assign code_done = result_code == 8'd1 || result_code == 8'd2;
    assign code_fail = !code_cont && !code_warm && !code_done;

    always_comb begin
        state_d = state_q;
        core_d  = core_q;
        nstep_d = nstep_q;
        last_d  = last_q;
        done_d  = done_q;
        fail_d  = fail_q;
        clean_d = 1'b0;
        dump_d  = 1'b0;
        perr_d  = perr_q | drop_any |
                  (result_valid && state_q != S_WAIT);
        unique case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    state_d = S_ISSUE;
                    core_d  = gnt_idx;
                    nstep_d = gnt_n;
                    last_d  = gnt_idx;
                end
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (result_valid) begin
                    unique case (1'b1)
                        code_cont: state_d = S_IDLE;
                        code_warm: begin
                            state_d = S_IDLE;
                            clean_d = 1'b1;
                        end
                        code_done: begin
                            state_d = S_HALT;
                            done_d  = 1'b1;
                            dump_d  = 1'b1;
                        end
                        code_fail: begin
                            state_d = S_HALT;
                            fail_d  = 1'b1;
                            dump_d  = 1'b1;
                        end
                        default: state_d = S_HALT;
                    endcase
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            core_q  <= '0;
            last_q  <= 3'(NUM_CORES - 1);
            nstep_q <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            clean_q <= 1'b0;
            dump_q  <= 1'b0;
            perr_q  <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            core_q  <= core_d;
            last_q  <= last_d;
            nstep_q <= nstep_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            clean_q <= clean_d;
            dump_q  <= dump_d;
            perr_q  <= perr_d;
            for (int i = 0; i < NUM_CORES; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign issue_valid  = state_q == S_ISSUE;
    assign issue_core   = core_q;
    assign issue_nstep  = nstep_q;
    assign sim_done     = done_q;
    assign sim_fail     = fail_q;
    assign perf_clean   = clean_q;
    assign perf_dump    = dump_q;
    assign protocol_err = perr_q;
    assign pending      = acc_nz || state_q == S_ISSUE || state_q == S_WAIT;

endmodule

// File: tb/tb_difftest_step_scheduler.sv
// Directed bench for difftest_step_scheduler (2 cores, 8-bit steps, 9-bit acc).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_difftest_step_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] core_step;
    logic [1:0]  core_ready;
    logic        issue_valid;
    logic [2:0]  issue_core;
    logic [7:0]  issue_nstep;
    logic        issue_ready;
    logic        result_valid;
    logic [7:0]  result_code;
    logic        sim_done;
    logic        sim_fail;
    logic        perf_clean;
    logic        perf_dump;
    logic        protocol_err;
    logic        pending;

    int tests = 0;
    int fails = 0;

    difftest_step_scheduler #(
        .NUM_CORES (2),
        .STEP_WIDTH(8),
        .ACC_WIDTH (9)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .core_step   (core_step),
        .core_ready  (core_ready),
        .issue_valid (issue_valid),
        .issue_core  (issue_core),
        .issue_nstep (issue_nstep),
        .issue_ready (issue_ready),
        .result_valid(result_valid),
        .result_code (result_code),
        .sim_done    (sim_done),
        .sim_fail    (sim_fail),
        .perf_clean  (perf_clean),
        .perf_dump   (perf_dump),
        .protocol_err(protocol_err),
        .pending     (pending)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] outs();
        return {issue_valid, issue_core, issue_nstep, sim_done, sim_fail,
                perf_clean, perf_dump, protocol_err, pending, core_ready};
    endfunction

    // Leaves the bench on a falling edge with reset released (cycle 0).
    task automatic do_reset();
        reset        = 1'b1;
        core_step    = '0;
        issue_ready  = 1'b0;
        result_valid = 1'b0;
        result_code  = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (outs() !== 20'h00003) begin
            fails++;
            $display("FAIL reset_outs got %h want 00003", outs());
        end
    endtask

    task automatic test_single();
        do_reset();
        core_step = 16'd3;
        @(negedge clock);
        core_step = '0;
        tests++;
        if (issue_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_early got %b want 0", issue_valid);
        end
        @(negedge clock);
        tests++;
        if ({issue_valid, issue_core, issue_nstep} !== {1'b1, 3'd0, 8'd3}) begin
            fails++;
            $display("FAIL single_issue got %b/%0d/%0d want 1/0/3",
                     issue_valid, issue_core, issue_nstep);
        end
        issue_ready = 1'b1;
        @(negedge clock);
        issue_ready  = 1'b0;
        result_valid = 1'b1;
        result_code  = 8'd0;
        @(negedge clock);
        result_valid = 1'b0;
        tests++;
        if ({pending, issue_valid} !== 2'b00) begin
            fails++;
            $display("FAIL single_idle got pend=%b valid=%b want 0 0",
                     pending, issue_valid);
        end
    endtask

    task automatic test_back_to_back();
        int   n_iss = 0;
        int   sum = 0;
        bit   res_next = 1'b0;
        bit   done = 1'b0;
        int   cores [4];
        int   nst [4];
        int   exp_c [4] = '{0, 1, 0, 1};
        int   exp_n [4] = '{1, 4, 6, 6};
        do_reset();
        issue_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (issue_valid) begin
                if (n_iss < 4) begin
                    cores[n_iss] = int'(issue_core);
                    nst[n_iss]   = int'(issue_nstep);
                end
                n_iss++;
                sum += int'(issue_nstep);
            end
            if (cyc > 12 && !pending) done = 1'b1;
            core_step    = (cyc < 12) ? 16'h0101 : 16'h0000;
            result_valid = res_next;
            result_code  = 8'd0;
            res_next     = issue_valid;
            @(negedge clock);
        end
        core_step    = '0;
        issue_ready  = 1'b0;
        result_valid = 1'b0;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL b2b_drain timeout pending=%b", pending);
        end
        tests++;
        if (n_iss !== 6) begin
            fails++;
            $display("FAIL b2b_count got %0d want 6", n_iss);
        end
        tests++;
        if (sum !== 24) begin
            fails++;
            $display("FAIL b2b_total got %0d want 24", sum);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (cores[i] !== exp_c[i] || nst[i] !== exp_n[i]) begin
                fails++;
                $display("FAIL b2b_grant%0d got core %0d n %0d want core %0d n %0d",
                         i, cores[i], nst[i], exp_c[i], exp_n[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int sum = 0;
        bit res_next = 1'b0;
        bit done = 1'b0;
        do_reset();
        core_step = 16'h00FF;
        @(negedge clock);
        @(negedge clock);
        tests++;
        if ({core_ready[0], issue_valid, issue_nstep} !== {2'b11, 8'd255}) begin
            fails++;
            $display("FAIL sat_first got rdy=%b v=%b n=%0d want 1 1 255",
                     core_ready[0], issue_valid, issue_nstep);
        end
        @(negedge clock);
        tests++;
        if (core_ready[0] !== 1'b0) begin
            fails++;
            $display("FAIL sat_ready_drop got %b want 0", core_ready[0]);
        end
        @(negedge clock);
        tests++;
        if ({protocol_err, core_ready[0], issue_nstep} !== {2'b10, 8'd255}) begin
            fails++;
            $display("FAIL sat_hold got perr=%b rdy=%b n=%0d want 1 0 255",
                     protocol_err, core_ready[0], issue_nstep);
        end
        core_step   = '0;
        issue_ready = 1'b1;
        @(negedge clock);
        issue_ready  = 1'b0;
        result_valid = 1'b1;
        result_code  = 8'd0;
        @(negedge clock);
        result_valid = 1'b0;
        @(negedge clock);
        tests++;
        if ({issue_valid, issue_nstep, core_ready[0]} !== {1'b1, 8'd255, 1'b1}) begin
            fails++;
            $display("FAIL sat_regrant got v=%b n=%0d rdy=%b want 1 255 1",
                     issue_valid, issue_nstep, core_ready[0]);
        end
        issue_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (issue_valid) sum += int'(issue_nstep);
            if (!pending) done = 1'b1;
            result_valid = res_next;
            result_code  = 8'd0;
            res_next     = issue_valid;
            @(negedge clock);
        end
        issue_ready  = 1'b0;
        result_valid = 1'b0;
        tests++;
        if (!done || sum !== 510) begin
            fails++;
            $display("FAIL sat_drain got sum %0d done %b want 510 1", sum, done);
        end
    endtask

    task automatic test_warmup();
        do_reset();
        core_step = 16'd1;
        @(negedge clock);
        core_step = '0;
        @(negedge clock);
        issue_ready = 1'b1;
        @(negedge clock);
        issue_ready  = 1'b0;
        result_valid = 1'b1;
        result_code  = 8'd4;
        @(negedge clock);
        result_valid = 1'b0;
        tests++;
        if ({perf_clean, pending, sim_done, sim_fail} !== 4'b1000) begin
            fails++;
            $display("FAIL warm_pulse got clean=%b pend=%b done=%b fail=%b want 1 0 0 0",
                     perf_clean, pending, sim_done, sim_fail);
        end
        @(negedge clock);
        tests++;
        if (perf_clean !== 1'b0) begin
            fails++;
            $display("FAIL warm_width got %b want 0", perf_clean);
        end
    endtask

    task automatic test_terminal(input logic [7:0] code,
                                 input logic exp_done,
                                 input logic exp_fail);
        int n_iss = 0;
        do_reset();
        core_step = 16'd1;
        @(negedge clock);
        core_step = '0;
        @(negedge clock);
        issue_ready = 1'b1;
        @(negedge clock);
        issue_ready  = 1'b0;
        result_valid = 1'b1;
        result_code  = code;
        @(negedge clock);
        result_valid = 1'b0;
        tests++;
        if ({sim_done, sim_fail, perf_dump} !== {exp_done, exp_fail, 1'b1}) begin
            fails++;
            $display("FAIL term%0d_rise got %b%b%b want %b%b1",
                     code, sim_done, sim_fail, perf_dump, exp_done, exp_fail);
        end
        core_step   = 16'h0303;
        issue_ready = 1'b1;
        @(negedge clock);
        tests++;
        if ({sim_done, sim_fail, perf_dump} !== {exp_done, exp_fail, 1'b0}) begin
            fails++;
            $display("FAIL term%0d_hold got %b%b%b want %b%b0",
                     code, sim_done, sim_fail, perf_dump, exp_done, exp_fail);
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (issue_valid) n_iss++;
            @(negedge clock);
        end
        core_step   = '0;
        issue_ready = 1'b0;
        tests++;
        if (n_iss !== 0) begin
            fails++;
            $display("FAIL term%0d_noissue got %0d want 0", code, n_iss);
        end
    endtask

    task automatic test_idle_result();
        do_reset();
        result_valid = 1'b1;
        result_code  = 8'd1;
        @(negedge clock);
        result_valid = 1'b0;
        tests++;
        if ({protocol_err, sim_done, pending} !== 3'b100) begin
            fails++;
            $display("FAIL idle_res got perr=%b done=%b pend=%b want 1 0 0",
                     protocol_err, sim_done, pending);
        end
        core_step = 16'd2;
        @(negedge clock);
        core_step = '0;
        @(negedge clock);
        tests++;
        if ({issue_valid, issue_core, issue_nstep} !== {1'b1, 3'd0, 8'd2}) begin
            fails++;
            $display("FAIL idle_res_issue got %b/%0d/%0d want 1/0/2",
                     issue_valid, issue_core, issue_nstep);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        core_step = 16'd1;
        @(negedge clock);
        core_step = '0;
        @(negedge clock);
        issue_ready  = 1'b1;
        result_valid = 1'b1;
        result_code  = 8'd0;
        @(negedge clock);
        issue_ready  = 1'b0;
        result_valid = 1'b0;
        tests++;
        if ({protocol_err, pending, issue_valid} !== 3'b110) begin
            fails++;
            $display("FAIL arst_pre got perr=%b pend=%b v=%b want 1 1 0",
                     protocol_err, pending, issue_valid);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (outs() !== 20'h00003) begin
            fails++;
            $display("FAIL arst_clear got %h want 00003", outs());
        end
        @(negedge clock);
        reset        = 1'b0;
        result_valid = 1'b1;
        result_code  = 8'd0;
        @(negedge clock);
        result_valid = 1'b0;
        tests++;
        if ({protocol_err, sim_done, pending} !== 3'b100) begin
            fails++;
            $display("FAIL arst_late_res got perr=%b done=%b pend=%b want 1 0 0",
                     protocol_err, sim_done, pending);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_warmup();
        test_terminal(8'd1, 1'b1, 1'b0);
        test_terminal(8'd2, 1'b1, 1'b0);
        test_terminal(8'd3, 1'b0, 1'b1);
        test_terminal(8'd9, 1'b0, 1'b1);
        test_idle_result();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
